// File: rtl/eth_pcs_rx_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_pcs_rx_sync_ctrl_pkg
// Purpose : Shared PCS receive-path constants and types: sync header width,
//           data width, sync header codes, the block-lock FSM state type and
//           default lock / BER-monitor settings.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package eth_pcs_rx_sync_ctrl_pkg;

   localparam int W_SYNC = 2;
   localparam int W_DATA = 64;

   // The only two legal 66b sync headers
   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   typedef enum logic [1:0] {
      RESET_CNT = 2'd0,
      TEST_SH   = 2'd1,
      SLIP      = 2'd2,
      HOLDOFF   = 2'd3
   } lock_state_e;

   localparam int DEF_N_SH_TEST    = 64;
   localparam int DEF_N_SH_INVALID = 16;
   localparam int DEF_SLIP_HOLDOFF = 4;
   localparam int DEF_BER_WINDOW   = 19531;
   localparam int DEF_BER_THRESH   = 16;
   localparam int DEF_W_BER_CNT    = 6;

endpackage
`default_nettype wire

// File: rtl/eth_pcs_rx_sync_ctrl_ber_mon.sv
`default_nettype none
// ============================================================================
// Module  : eth_pcs_rx_ber_mon
// Purpose : Bit-error-rate monitor. Counts invalid sync headers inside a
//           fixed window of clk_en-qualified cycles and flags high BER when
//           the count reaches the threshold.
// Ports   : i_clk, i_reset  - clock, synchronous active-high reset
//           i_clk_en        - gearbox data-valid strobe (timer advance)
//           i_run           - monitor active (block lock held); 0 clears all
//           i_bad_hdr       - invalid header event this cycle
//           o_hi_ber        - high bit-error rate
//           o_ber_count     - saturating invalid-header count of the window
// Rev     : 1.0  initial release
// ============================================================================
module eth_pcs_rx_ber_mon #(
   parameter int BER_WINDOW = 19531,
   parameter int BER_THRESH = 16,
   parameter int W_BER_CNT  = 6
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_clk_en,
   input  logic                 i_run,
   input  logic                 i_bad_hdr,
   output logic                 o_hi_ber,
   output logic [W_BER_CNT-1:0] o_ber_count
);

   localparam int                     c_w_timer    = $clog2(BER_WINDOW + 1);
   localparam logic [c_w_timer-1:0]   c_timer_last = c_w_timer'(BER_WINDOW - 1);
   localparam logic [W_BER_CNT-1:0]   c_cnt_max    = '1;

   logic [c_w_timer-1:0] r_timer;
   logic [W_BER_CNT-1:0] r_cnt;
   logic                 r_hi;
   logic [W_BER_CNT-1:0] w_cnt_nxt;
   logic                 w_over;
   logic                 w_wrap;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_bad_hdr && (r_cnt != c_cnt_max)) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
      // Uses the count including this cycle's header, so an invalid header
      // in the wrap cycle still counts toward the ending window's decision.
      w_over = (32'(w_cnt_nxt) >= 32'(BER_THRESH));
      w_wrap = (r_timer == c_timer_last);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || !i_run) begin
         r_timer <= '0;
         r_cnt   <= '0;
         r_hi    <= 1'b0;
      end else if (i_clk_en) begin
         if (w_wrap) begin
            r_timer <= '0;
            r_cnt   <= '0;
            r_hi    <= w_over;
         end else begin
            r_timer <= r_timer + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= r_hi | w_over;
         end
      end
   end

   assign o_hi_ber    = r_hi;
   assign o_ber_count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/eth_pcs_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : eth_pcs_rx_sync_ctrl
// Purpose : RX synchronisation controller between the gearbox and the
//           descrambler: 66b block-lock FSM with slip request to the gearbox
//           and an attached BER monitor.
// Ports   : i_clk, i_reset  - clock, synchronous active-high reset
//           i_clk_en        - gearbox data-valid strobe; all state gated by it
//           i_hdr_valid     - gearbox header-valid flag
//           i_hdr           - received sync header
//           o_slip          - one-cycle bit-slip request to the gearbox
//           o_block_lock    - block lock achieved
//           o_hi_ber        - high bit-error rate
//           o_ber_count     - saturating invalid-header count (BER window)
// Rev     : 1.0  initial release
// ============================================================================
module eth_pcs_rx_sync_ctrl #(
   parameter int W_SYNC       = eth_pcs_rx_sync_ctrl_pkg::W_SYNC,
   parameter int N_SH_TEST    = eth_pcs_rx_sync_ctrl_pkg::DEF_N_SH_TEST,
   parameter int N_SH_INVALID = eth_pcs_rx_sync_ctrl_pkg::DEF_N_SH_INVALID,
   parameter int SLIP_HOLDOFF = eth_pcs_rx_sync_ctrl_pkg::DEF_SLIP_HOLDOFF,
   parameter int BER_WINDOW   = eth_pcs_rx_sync_ctrl_pkg::DEF_BER_WINDOW,
   parameter int BER_THRESH   = eth_pcs_rx_sync_ctrl_pkg::DEF_BER_THRESH,
   parameter int W_BER_CNT    = eth_pcs_rx_sync_ctrl_pkg::DEF_W_BER_CNT
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_clk_en,
   input  logic                 i_hdr_valid,
   input  logic [W_SYNC-1:0]    i_hdr,
   output logic                 o_slip,
   output logic                 o_block_lock,
   output logic                 o_hi_ber,
   output logic [W_BER_CNT-1:0] o_ber_count
);

   import eth_pcs_rx_sync_ctrl_pkg::*;

   localparam int c_w_sh   = $clog2(N_SH_TEST + 1);
   localparam int c_w_inv  = $clog2(N_SH_INVALID + 1);
   localparam int c_w_hold = (SLIP_HOLDOFF > 0) ? $clog2(SLIP_HOLDOFF + 1) : 1;

   lock_state_e         r_state,   w_state_nxt;
   logic [c_w_sh-1:0]   r_sh_cnt,  w_sh_cnt_nxt,  w_sh_inc;
   logic [c_w_inv-1:0]  r_inv_cnt, w_inv_cnt_nxt, w_inv_inc;
   logic [c_w_hold-1:0] r_hold_cnt, w_hold_cnt_nxt, w_hold_dec;
   logic                r_block_lock, w_block_lock_nxt;
   logic                r_slip, w_slip_nxt;
   logic                w_hdr_bad;
   logic                w_hdr_evt;
   logic                w_ber_run;

   assign w_hdr_evt = i_clk_en && i_hdr_valid;
   assign w_hdr_bad = (i_hdr != W_SYNC'(SYNC_DATA)) && (i_hdr != W_SYNC'(SYNC_CTRL));

   assign w_sh_inc   = r_sh_cnt + 1'b1;
   assign w_inv_inc  = r_inv_cnt + c_w_inv'(w_hdr_bad);
   assign w_hold_dec = r_hold_cnt - 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= RESET_CNT;
         r_sh_cnt     <= '0;
         r_inv_cnt    <= '0;
         r_hold_cnt   <= '0;
         r_block_lock <= 1'b0;
         r_slip       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sh_cnt     <= w_sh_cnt_nxt;
         r_inv_cnt    <= w_inv_cnt_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
         r_block_lock <= w_block_lock_nxt;
         r_slip       <= w_slip_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_sh_cnt_nxt     = r_sh_cnt;
      w_inv_cnt_nxt    = r_inv_cnt;
      w_hold_cnt_nxt   = r_hold_cnt;
      w_block_lock_nxt = r_block_lock;
      // Slip is a pulse: it drops on the next edge whether or not clk_en is high
      w_slip_nxt       = 1'b0;

      if (i_clk_en) begin
         case (r_state)
            RESET_CNT: begin
               w_sh_cnt_nxt  = '0;
               w_inv_cnt_nxt = '0;
               w_state_nxt   = TEST_SH;
            end
            TEST_SH: begin
               if (i_hdr_valid) begin
                  w_sh_cnt_nxt  = w_sh_inc;
                  w_inv_cnt_nxt = w_inv_inc;
                  // Slip takes priority over a window that completes on the same header
                  if ((w_hdr_bad && !r_block_lock) ||
                      (w_inv_inc == c_w_inv'(N_SH_INVALID))) begin
                     w_state_nxt      = SLIP;
                     w_block_lock_nxt = 1'b0;
                     w_slip_nxt       = 1'b1;
                  end else if (w_sh_inc == c_w_sh'(N_SH_TEST)) begin
                     w_state_nxt = RESET_CNT;
                     if (w_inv_inc == '0) begin
                        w_block_lock_nxt = 1'b1;
                     end
                  end
               end
            end
            SLIP: begin
               w_hold_cnt_nxt = c_w_hold'(SLIP_HOLDOFF);
               w_state_nxt    = (SLIP_HOLDOFF == 0) ? RESET_CNT : HOLDOFF;
            end
            HOLDOFF: begin
               if (i_hdr_valid) begin
                  w_hold_cnt_nxt = w_hold_dec;
                  if (w_hold_dec == '0) begin
                     w_state_nxt = RESET_CNT;
                  end
               end
            end
            default: begin
               w_state_nxt = RESET_CNT;
            end
         endcase
      end
   end

   // The monitor clears on the same edge that lock is dropped, so hi_ber
   // and the count never outlive block lock.
   assign w_ber_run = r_block_lock && w_block_lock_nxt;

   eth_pcs_rx_ber_mon #(
      .BER_WINDOW (BER_WINDOW),
      .BER_THRESH (BER_THRESH),
      .W_BER_CNT  (W_BER_CNT)
   ) u_ber_mon (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_clk_en    (i_clk_en),
      .i_run       (w_ber_run),
      .i_bad_hdr   (w_hdr_evt && w_hdr_bad),
      .o_hi_ber    (o_hi_ber),
      .o_ber_count (o_ber_count)
   );

   assign o_slip       = r_slip;
   assign o_block_lock = r_block_lock;

endmodule
`default_nettype wire

// File: tb/tb_eth_pcs_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_pcs_rx_sync_ctrl
// Purpose : Self-checking bench for eth_pcs_rx_sync_ctrl: behavioural model
//           compared every cycle plus hand-computed literal expectations.
// Rev     : 1.0  initial release
// ============================================================================
module tb_eth_pcs_rx_sync_ctrl;

   localparam int N_TEST = 64;
   localparam int N_INV  = 16;
   localparam int HOLD   = 4;
   localparam int WIN    = 200;
   localparam int THRESH = 16;
   localparam int WCNT   = 6;
   localparam int CMAX   = (1 << WCNT) - 1;

   logic            i_clk = 1'b0;
   logic            i_reset;
   logic            i_clk_en;
   logic            i_hdr_valid;
   logic [1:0]      i_hdr;
   logic            o_slip;
   logic            o_block_lock;
   logic            o_hi_ber;
   logic [WCNT-1:0] o_ber_count;

   int n_chk  = 0;
   int n_fail = 0;

   eth_pcs_rx_sync_ctrl #(
      .W_SYNC       (2),
      .N_SH_TEST    (N_TEST),
      .N_SH_INVALID (N_INV),
      .SLIP_HOLDOFF (HOLD),
      .BER_WINDOW   (WIN),
      .BER_THRESH   (THRESH),
      .W_BER_CNT    (WCNT)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clk_en     (i_clk_en),
      .i_hdr_valid  (i_hdr_valid),
      .i_hdr        (i_hdr),
      .o_slip       (o_slip),
      .o_block_lock (o_block_lock),
      .o_hi_ber     (o_hi_ber),
      .o_ber_count  (o_ber_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = clearing counters, 1 = testing headers, 2 = slip issued,
   //        3 = ignoring headers after slip
   int m_phase, m_sh, m_inv, m_hold, m_timer, m_ber;
   bit m_lock, m_slip, m_hi, m_started = 0;
   bit m_was_locked, m_bad;

   always @(posedge i_clk) begin
      if (i_reset) begin
         m_phase = 0; m_sh = 0; m_inv = 0; m_hold = 0;
         m_timer = 0; m_ber = 0;
         m_lock = 0; m_slip = 0; m_hi = 0;
         m_started = 1;
      end else begin
         m_slip = 0;
         if (i_clk_en) begin
            m_bad = !(i_hdr == 2'b01 || i_hdr == 2'b10);
            m_was_locked = m_lock;
            case (m_phase)
               0: begin m_sh = 0; m_inv = 0; m_phase = 1; end
               1: if (i_hdr_valid) begin
                     m_sh++;
                     if (m_bad) m_inv++;
                     if ((m_bad && !m_lock) || m_inv == N_INV) begin
                        m_lock = 0; m_slip = 1; m_phase = 2;
                     end else if (m_sh == N_TEST) begin
                        if (m_inv == 0) m_lock = 1;
                        m_phase = 0;
                     end
                  end
               2: begin m_hold = HOLD; m_phase = (HOLD == 0) ? 0 : 3; end
               default: if (i_hdr_valid) begin
                     m_hold--;
                     if (m_hold == 0) m_phase = 0;
                  end
            endcase
            if (m_was_locked && m_lock) begin
               if (i_hdr_valid && m_bad && m_ber < CMAX) m_ber++;
               if (m_ber == THRESH) m_hi = 1;
               if (m_timer == WIN - 1) begin
                  if (m_ber < THRESH) m_hi = 0;
                  m_ber = 0;
                  m_timer = 0;
               end else begin
                  m_timer++;
               end
            end else begin
               m_timer = 0; m_ber = 0; m_hi = 0;
            end
         end
      end
   end

   always @(negedge i_clk) begin
      if (m_started) begin
         chk("model_slip",  32'(o_slip),       32'(m_slip));
         chk("model_lock",  32'(o_block_lock), 32'(m_lock));
         chk("model_hiber", 32'(o_hi_ber),     32'(m_hi));
         chk("model_count", 32'(o_ber_count),  32'(m_ber));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic en, input logic v, input logic [1:0] h);
      i_clk_en    = en;
      i_hdr_valid = v;
      i_hdr       = h;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_slip"},  32'(o_slip),       0);
      chk({name, "_lock"},  32'(o_block_lock), 0);
      chk({name, "_hiber"}, 32'(o_hi_ber),     0);
      chk({name, "_count"}, 32'(o_ber_count),  0);
   endtask

   // One cycle to leave the counter-clear state, then N_TEST clean headers
   task automatic lock_seq(input string name);
      drive(1, 1, 2'b01);
      for (int i = 1; i <= N_TEST; i++) begin
         drive(1, 1, 2'b01);
         if (i == N_TEST - 1) chk({name, "_lock_63"}, 32'(o_block_lock), 0);
         if (i == N_TEST)     chk({name, "_lock_64"}, 32'(o_block_lock), 1);
      end
   endtask

   function automatic bit t5_bad(input int k);
      case (k)
         10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110, 120,
         132, 133, 134, 135, 250, 300, 350: return 1'b1;
         default: return ((k >= 401 && k <= 410) || (k >= 460 && k <= 465));
      endcase
   endfunction

   initial begin
      i_reset = 1'b1; i_clk_en = 1'b0; i_hdr_valid = 1'b0; i_hdr = 2'b00;
      drive(1, 1, 2'b11);
      drive(1, 1, 2'b11);
      chk_all_zero("reset");
      i_reset = 1'b0;

      // Basic lock: 64 clean headers, lock the cycle after the 64th
      lock_seq("t1");

      // Unlocked slip, holdoff ignores headers, relock needs 64 more
      i_reset = 1'b1; drive(1, 1, 2'b01); i_reset = 1'b0;
      chk("t2_reset_lock", 32'(o_block_lock), 0);
      drive(1, 0, 2'b00);
      for (int i = 0; i < 10; i++) drive(1, 1, 2'b10);
      drive(1, 1, 2'b11);
      chk("t2_slip_pulse", 32'(o_slip), 1);
      drive(1, 1, 2'b01);
      chk("t2_slip_end", 32'(o_slip), 0);
      for (int i = 0; i < HOLD; i++) drive(1, 1, 2'b11);
      chk("t2_holdoff_noslip", 32'(o_slip), 0);
      lock_seq("t2");

      // Locked: 15 invalid in a window keeps lock
      drive(1, 1, 2'b01);
      for (int i = 1; i <= N_TEST; i++)
         drive(1, 1, (i % 4 == 0 && i <= 60) ? 2'b11 : 2'b01);
      chk("t3_lock_held", 32'(o_block_lock), 1);
      chk("t3_no_slip",   32'(o_slip), 0);

      // Locked: 16th invalid in a window forces slip and drops lock
      drive(1, 1, 2'b01);
      for (int i = 1; i <= 48; i++)
         drive(1, 1, (i % 3 == 0) ? 2'b11 : 2'b01);
      chk("t3_slip16_slip",  32'(o_slip), 1);
      chk("t3_slip16_lock",  32'(o_block_lock), 0);
      chk("t3_slip16_hiber", 32'(o_hi_ber), 0);

      // Reset during holdoff: next edge all zero, then lock test restarts at once
      drive(1, 1, 2'b01);
      drive(1, 1, 2'b01);
      drive(1, 1, 2'b01);
      i_reset = 1'b1; drive(1, 1, 2'b01); i_reset = 1'b0;
      chk_all_zero("t4_reset_holdoff");
      lock_seq("t4");

      // BER window: k counts edges after the lock edge
      for (int k = 1; k <= 465; k++) begin
         drive(1, 1, t5_bad(k) ? 2'b11 : 2'b01);
         if (k == 134) begin
            chk("t5_k134_hiber", 32'(o_hi_ber), 0);
            chk("t5_k134_count", 32'(o_ber_count), 15);
         end
         if (k == 135) begin
            chk("t5_k135_hiber", 32'(o_hi_ber), 1);
            chk("t5_k135_count", 32'(o_ber_count), 16);
         end
         if (k == 399) begin
            chk("t5_k399_hiber", 32'(o_hi_ber), 1);
            chk("t5_k399_count", 32'(o_ber_count), 3);
         end
         if (k == 400) begin
            chk("t5_k400_hiber", 32'(o_hi_ber), 0);
            chk("t5_k400_count", 32'(o_ber_count), 0);
            chk("t5_k400_lock",  32'(o_block_lock), 1);
         end
         if (k == 465) chk("t5_k465_hiber", 32'(o_hi_ber), 1);
      end

      // Reset while hi_ber is set
      i_reset = 1'b1; drive(1, 1, 2'b01); i_reset = 1'b0;
      chk_all_zero("t6_reset_hiber");

      // clk_en toggling: disabled cycles carry invalid headers that must be ignored
      drive(1, 1, 2'b01);
      for (int i = 1; i <= N_TEST; i++) begin
         drive(0, 1, 2'b11);
         drive(1, 1, 2'b01);
         if (i == N_TEST - 1) chk("t7_lock_63", 32'(o_block_lock), 0);
         if (i == N_TEST)     chk("t7_lock_64", 32'(o_block_lock), 1);
      end
      // Timer advances only on enabled cycles: wrap after 200 enabled = j 399
      for (int j = 1; j <= 420; j++) begin
         drive(j % 2 == 1, 1, (j == 5) ? 2'b11 : 2'b01);
         if (j == 398) chk("t7_j398_count", 32'(o_ber_count), 1);
         if (j == 399) chk("t7_j399_count", 32'(o_ber_count), 0);
      end

      drive(1, 0, 2'b00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
